// File: rtl/ysyx_040750_scoreboard.sv
// rtl/ysyx_040750_scoreboard.sv - register-write scoreboard for the ID hazard check
//
// Tracks in-flight rd writers per architectural register and in-flight mrets.
// Issue (from ID) increments, retire (from WB) decrements, avail (from EX/MEM)
// marks a late result as forwardable. Queries from ID are answered from registered state.
//
// Ports:
//   I_sys_clk, I_rst_n             clock, synchronous active-low reset
//   I_flush                        clear all tracking state except err
//   I_issue_*, O_issue_ready       issue handshake and fields
//   I_avail_valid/rd_addr          late result became forwardable
//   I_retire_*                     WB commit
//   I_rs1_addr/rs2_addr/stall_en   ID source queries
//   O_rs_busy, O_ID_stall, O_err   query answers, stall request, sticky error

module ysyx_040750_scoreboard #(
    parameter int CNT_W  = 2,
    parameter int MRET_W = 2
) (
    input  logic       I_sys_clk,
    input  logic       I_rst_n,
    input  logic       I_flush,
    input  logic       I_issue_valid,
    output logic       O_issue_ready,
    input  logic [4:0] I_issue_rd_addr,
    input  logic       I_issue_wen,
    input  logic       I_issue_late,
    input  logic       I_issue_mret,
    input  logic       I_avail_valid,
    input  logic [4:0] I_avail_rd_addr,
    input  logic       I_retire_valid,
    input  logic [4:0] I_retire_rd_addr,
    input  logic       I_retire_wen,
    input  logic       I_retire_mret,
    input  logic [4:0] I_rs1_addr,
    input  logic [4:0] I_rs2_addr,
    input  logic [1:0] I_stall_en,
    output logic [1:0] O_rs_busy,
    output logic       O_ID_stall,
    output logic       O_err
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [MRET_W-1:0] MRET_MAX = {MRET_W{1'b1}};

    // Entry 0 exists only to keep indexing simple; it is never written and stays 0.
    logic [CNT_W-1:0]  cnt [32];
    logic [31:0]       late;
    logic [MRET_W-1:0] mret_cnt;
    logic              err;

    logic accept;
    logic iss_w;
    logic ret_w;
    logic avl_w;
    logic inc_m;
    logic dec_m;
    logic same_rd;
    logic err_set;

    logic issue_rd_nz;
    assign issue_rd_nz = (I_issue_rd_addr != 5'd0);

    // Ready looks only at state and issue fields so ID can use it before deciding valid.
    always_comb begin
        O_issue_ready = 1'b1;
        if (I_issue_wen && issue_rd_nz && (cnt[I_issue_rd_addr] == CNT_MAX))
            O_issue_ready = 1'b0;
        if (I_issue_wen && issue_rd_nz && I_issue_late && late[I_issue_rd_addr])
            O_issue_ready = 1'b0;
        if (I_issue_mret && (mret_cnt == MRET_MAX))
            O_issue_ready = 1'b0;
    end

    assign accept  = I_issue_valid & O_issue_ready;
    assign iss_w   = accept & I_issue_wen & issue_rd_nz;
    assign ret_w   = I_retire_valid & I_retire_wen & (I_retire_rd_addr != 5'd0);
    assign avl_w   = I_avail_valid & (I_avail_rd_addr != 5'd0);
    assign inc_m   = accept & I_issue_mret;
    assign dec_m   = I_retire_valid & I_retire_mret;
    assign same_rd = iss_w & ret_w & (I_issue_rd_addr == I_retire_rd_addr);

    // Underflow of a register counter is only an error when no same-cycle issue
    // offsets the retire; mret underflow likewise.
    always_comb begin
        err_set = 1'b0;
        if (ret_w && !same_rd && (cnt[I_retire_rd_addr] == '0))
            err_set = 1'b1;
        if (avl_w && !late[I_avail_rd_addr])
            err_set = 1'b1;
        if (dec_m && !inc_m && (mret_cnt == '0))
            err_set = 1'b1;
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_rst_n) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
            late     <= '0;
            mret_cnt <= '0;
            err      <= 1'b0;
        end else if (I_flush) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
            late     <= '0;
            mret_cnt <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                logic inc;
                logic dec;
                inc = iss_w && (I_issue_rd_addr == 5'(i));
                dec = ret_w && (I_retire_rd_addr == 5'(i));
                if (inc && !dec)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec && !inc && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - 1'b1;
                // Youngest writer decides lateness; issue overrides a same-cycle avail.
                if (inc)
                    late[i] <= I_issue_late;
                else if (avl_w && (I_avail_rd_addr == 5'(i)))
                    late[i] <= 1'b0;
            end
            if (inc_m && !dec_m)
                mret_cnt <= mret_cnt + 1'b1;
            else if (dec_m && !inc_m && (mret_cnt != '0))
                mret_cnt <= mret_cnt - 1'b1;
            if (err_set)
                err <= 1'b1;
        end
    end

    assign O_rs_busy[1] = I_stall_en[1] & (I_rs1_addr != 5'd0) & (cnt[I_rs1_addr] != '0);
    assign O_rs_busy[0] = I_stall_en[0] & (I_rs2_addr != 5'd0) & (cnt[I_rs2_addr] != '0);

    assign O_ID_stall = I_issue_valid & ((O_rs_busy[1] & late[I_rs1_addr])
                                       | (O_rs_busy[0] & late[I_rs2_addr])
                                       | (mret_cnt != '0)
                                       | !O_issue_ready);
    assign O_err = err;

endmodule

// File: tb/tb_ysyx_040750_scoreboard.sv
// tb/tb_ysyx_040750_scoreboard.sv - directed vector bench for ysyx_040750_scoreboard

module tb_ysyx_040750_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_rd;
    logic       issue_wen;
    logic       issue_late;
    logic       issue_mret;
    logic       avail_valid;
    logic [4:0] avail_rd;
    logic       retire_valid;
    logic [4:0] retire_rd;
    logic       retire_wen;
    logic       retire_mret;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] stall_en;
    logic [1:0] rs_busy;
    logic       id_stall;
    logic       err;

    always #5 clk = ~clk;

    ysyx_040750_scoreboard dut (
        .I_sys_clk        (clk),
        .I_rst_n          (rst_n),
        .I_flush          (flush),
        .I_issue_valid    (issue_valid),
        .O_issue_ready    (issue_ready),
        .I_issue_rd_addr  (issue_rd),
        .I_issue_wen      (issue_wen),
        .I_issue_late     (issue_late),
        .I_issue_mret     (issue_mret),
        .I_avail_valid    (avail_valid),
        .I_avail_rd_addr  (avail_rd),
        .I_retire_valid   (retire_valid),
        .I_retire_rd_addr (retire_rd),
        .I_retire_wen     (retire_wen),
        .I_retire_mret    (retire_mret),
        .I_rs1_addr       (rs1),
        .I_rs2_addr       (rs2),
        .I_stall_en       (stall_en),
        .O_rs_busy        (rs_busy),
        .O_ID_stall       (id_stall),
        .O_err            (err)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic [4:0] ird;
        logic       iwen;
        logic       ilate;
        logic       imret;
        logic       av;
        logic [4:0] ard;
        logic       rv;
        logic [4:0] rrd;
        logic       rwen;
        logic       rmret;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [1:0] sen;
        logic       e_ready;
        logic [1:0] e_busy;
        logic       e_stall;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic fl, input logic iv, input logic [4:0] ird, input logic iwen,
        input logic ilate, input logic imret, input logic av, input logic [4:0] ard,
        input logic rv, input logic [4:0] rrd, input logic rwen, input logic rmret,
        input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] sen,
        input logic e_ready, input logic [1:0] e_busy, input logic e_stall, input logic e_err);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ird = ird; v.iwen = iwen; v.ilate = ilate; v.imret = imret;
        v.av = av; v.ard = ard; v.rv = rv; v.rrd = rrd; v.rwen = rwen; v.rmret = rmret;
        v.s1 = s1; v.s2 = s2; v.sen = sen;
        v.e_ready = e_ready; v.e_busy = e_busy; v.e_stall = e_stall; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl; issue_valid = v.iv; issue_rd = v.ird; issue_wen = v.iwen;
        issue_late = v.ilate; issue_mret = v.imret; avail_valid = v.av; avail_rd = v.ard;
        retire_valid = v.rv; retire_rd = v.rrd; retire_wen = v.rwen; retire_mret = v.rmret;
        rs1 = v.s1; rs2 = v.s2; stall_en = v.sen;
    endtask

    task automatic check_outputs(input vec_t v, input int idx);
        check("ready", idx, {1'b0, issue_ready}, {1'b0, v.e_ready});
        check("busy",  idx, rs_busy, v.e_busy);
        check("stall", idx, {1'b0, id_stall}, {1'b0, v.e_stall});
        check("err",   idx, {1'b0, err}, {1'b0, v.e_err});
    endtask

    // Apply inputs just after a rising edge, sample on the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        check_outputs(v, idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0);

        //            fl iv ird w lt mr  av ard  rv rrd rw rm  s1 s2 sen     rdy busy  stl err
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 0 idle after reset
        vecs.push_back(mk(0,1,5,1,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 1 issue add rd5
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 5,0,2'b10, 1,2'b10,0,0)); // 2 rs1=5 busy, no stall
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,5,1,0, 5,0,2'b10, 1,2'b10,0,0)); // 3 retire rd5, not bypassed
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 5,0,2'b10, 1,2'b00,0,0)); // 4 rd5 free
        vecs.push_back(mk(0,1,7,1,1,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 5 issue load rd7
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 0,7,2'b01, 1,2'b01,1,0)); // 6 rs2=7 late -> stall
        vecs.push_back(mk(0,1,0,0,0,0, 1,7, 0,0,0,0, 0,7,2'b01, 1,2'b01,1,0)); // 7 avail rd7 same cycle
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 0,7,2'b01, 1,2'b01,0,0)); // 8 forwardable
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 1,7,1,0, 0,7,2'b01, 1,2'b01,0,0)); // 9 retire rd7
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 0,7,2'b01, 1,2'b00,0,0)); // 10 rd7 free
        vecs.push_back(mk(0,1,3,1,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 11 rd3 cnt=1
        vecs.push_back(mk(0,1,3,1,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 12 rd3 cnt=2
        vecs.push_back(mk(0,1,3,1,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 13 rd3 cnt=3
        vecs.push_back(mk(0,1,3,1,0,0, 0,0, 1,3,1,0, 0,0,2'b00, 0,2'b00,1,0)); // 14 saturated, retire rd3
        vecs.push_back(mk(0,1,3,1,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 15 room again, cnt=3
        vecs.push_back(mk(0,1,8,1,1,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 16 load rd8
        vecs.push_back(mk(0,1,8,1,1,0, 0,0, 0,0,0,0, 0,0,2'b00, 0,2'b00,1,0)); // 17 second late rd8 blocked
        vecs.push_back(mk(0,1,8,1,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 18 non-late rd8 ok
        vecs.push_back(mk(0,1,0,1,0,0, 0,0, 0,0,0,0, 0,0,2'b11, 1,2'b00,0,0)); // 19 x0 never busy
        vecs.push_back(mk(0,1,0,0,0,1, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 20 issue mret
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,1,0)); // 21 mret in flight
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 1,0,0,1, 0,0,2'b00, 1,2'b00,1,0)); // 22 retire mret
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 23 mret gone
        vecs.push_back(mk(0,1,0,0,0,1, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0)); // 24 issue mret again
        vecs.push_back(mk(1,1,0,0,0,0, 0,0, 0,0,0,0, 3,0,2'b10, 1,2'b10,1,0)); // 25 flush mid-flight
        vecs.push_back(mk(0,1,0,0,0,0, 0,0, 0,0,0,0, 3,8,2'b11, 1,2'b00,0,0)); // 26 all cleared
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,9,1,0, 0,0,2'b00, 1,2'b00,0,0)); // 27 retire rd9 unmatched
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 9,0,2'b10, 1,2'b00,0,1)); // 28 err set, cnt9 stays 0
        vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,1)); // 29 flush
        vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,1)); // 30 err survives flush

        // Reset held two cycles with issue traffic present.
        drive(idle);
        rst_n = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd5; issue_wen = 1'b1; issue_mret = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // Reset clears the sticky error; an avail with nothing late also flags it.
        drive(idle);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(idle, 100);
        run_vec(mk(0,0,0,0,0,0, 1,4, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,0), 101);
        run_vec(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,2'b00, 1,2'b00,0,1), 102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
